// File: rtl/clear_sequencer.sv
// Playfield clear sequencer: phases the row array through spawn/move/write/check/shift,
// collapses cleared rows top-down, counts lines. Optional score via CLEAR_SCORE_EN.
module clear_sequencer #(
  parameter int unsigned ROWS    = 20,
  parameter int unsigned LINE_W  = 16,
  parameter int unsigned SCORE_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               land,
  input  logic [ROWS-1:0]    row_full,
  input  logic               spawn_ok,
  output logic [2:0]         state,
  output logic [ROWS-1:0]    shift_row,
  output logic [LINE_W-1:0]  lines,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_over
);

  localparam int unsigned CNT_W = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    S_SPAWN, S_MOVE, S_WRITE, S_CHECK, S_CAPT, S_SHIFT, S_HALT
  } fsm_t;

  fsm_t              fsm;
  logic [ROWS-1:0]   pending;
  logic [ROWS-1:0]   pending_next;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W:0]   lines_sum;
  logic [LINE_W-1:0] lines_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [ROWS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(ROWS); i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Clearing the lowest set bit retires the topmost pending row.
  always_comb begin
    pending_next = pending & (pending - ROWS'(1));
    cnt          = popcount(row_full);
    lines_sum    = {1'b0, lines} + (LINE_W + 1)'(cnt);
    lines_next   = lines_sum[LINE_W] ? '1 : lines_sum[LINE_W-1:0];
  end

`ifdef CLEAR_SCORE_EN
  logic [SCORE_W:0]   score_add;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [SCORE_W-1:0] score_q;

  always_comb begin
    case (cnt)
      CNT_W'(0): score_add = '0;
      CNT_W'(1): score_add = (SCORE_W + 1)'(40);
      CNT_W'(2): score_add = (SCORE_W + 1)'(100);
      CNT_W'(3): score_add = (SCORE_W + 1)'(300);
      default:   score_add = (SCORE_W + 1)'(1200);
    endcase
    score_sum  = {1'b0, score_q} + score_add;
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset)                score_q <= '0;
    else if (fsm == S_CAPT)    score_q <= score_next;
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm     <= S_SPAWN;
      pending <= '0;
      lines   <= '0;
    end else begin
      case (fsm)
        S_SPAWN: fsm <= spawn_ok ? S_MOVE : S_HALT;
        S_MOVE:  if (land) fsm <= S_WRITE;
        S_WRITE: fsm <= S_CHECK;
        S_CHECK: fsm <= S_CAPT;
        S_CAPT: begin
          pending <= row_full;
          lines   <= lines_next;
          fsm     <= (|row_full) ? S_SHIFT : S_SPAWN;
        end
        S_SHIFT: begin
          pending <= pending_next;
          if (pending_next == '0) fsm <= S_SPAWN;
        end
        S_HALT:  fsm <= S_HALT;
        default: fsm <= S_SPAWN;
      endcase
    end
  end

  // Phase code and shift enables are pure decodes of the registered state and mask.
  always_comb begin
    state     = 3'b000;
    shift_row = '0;
    case (fsm)
      S_SPAWN: state = 3'b100;
      S_MOVE:  state = 3'b001;
      S_WRITE: state = 3'b010;
      S_CHECK: state = 3'b000;
      S_CAPT:  state = 3'b001;
      S_SHIFT: begin
        state     = 3'b011;
        shift_row = pending ^ (pending - ROWS'(1));
      end
      default: state = 3'b000;
    endcase
    busy      = (fsm != S_MOVE);
    game_over = (fsm == S_HALT);
  end

endmodule

// File: doc/clear_sequencer.md
# clear_sequencer

Sequences the row-array phases of the playfield after a piece lands: it broadcasts the 3-bit phase code and per-row shift enables to every row register, collects their full-row flags, and collapses cleared rows one shift pass at a time. It sits directly downstream of the row array (consuming each row's `shift` flag) and upstream of it (driving `state` and `shift_row`). It also counts cleared lines, optionally keeps a score, and declares game over when a new piece cannot spawn.

## Interface
- `ROWS`, 20: number of playfield rows; row 0 is the top row, row ROWS-1 the bottom row.
- `LINE_W`, 16: width of the cleared-line counter.
- `SCORE_W`, 20: width of the score output.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low; a 0 sampled at the rising edge of `clk` resets the block.
- `land`  in  1  single-cycle pulse: the active piece has locked. Sampled only in MOVE.
- `row_full`  in  ROWS  per-row `shift` flags from the row array; bit i belongs to row i.
- `spawn_ok`  in  1  spawn area is clear. Sampled only in SPAWN.
- `state`  out  3  phase code broadcast to all rows: 000 check/halt, 001 move, 010 write, 011 shift, 100 spawn.
- `shift_row`  out  ROWS  per-row load-from-above enable. Meaningful only when `state` is 011.
- `lines`  out  LINE_W  total rows cleared; saturating.
- `score`  out  SCORE_W  accumulated score; saturating. Tied to 0 when the score feature is compiled out.
- `busy`  out  1  high whenever the FSM is not in MOVE.
- `game_over`  out  1  high in HALT.

## Operation
- FSM states and the `state` code each drives:
  - SPAWN: 100
  - MOVE: 001
  - WRITE: 010
  - CHECK: 000
  - CAPT: 001
  - SHIFT: 011
  - HALT: 000
- `state` and `shift_row` are decoded from registered FSM state and registered masks.
- Transitions:
  - SPAWN: goes to MOVE if `spawn_ok`=1, otherwise to HALT.
  - MOVE: stays in MOVE until `land`=1, then goes to WRITE.
  - WRITE: lasts 1 cycle, then CHECK.
  - CHECK: lasts 1 cycle, then CAPT. During CHECK the rows zero any full row and raise `shift` for that row.
  - CAPT:
    - latches `pending <= row_full`.
    - if `pending` is nonzero, goes to SHIFT; otherwise goes to SPAWN.
    - adds popcount(row_full) to `lines`, saturating at 2^LINE_W-1.
  - SHIFT:
    - let k be the lowest set index in `pending` (topmost cleared row).
    - drive `shift_row[i]=1` for i ≤ k and 0 otherwise, then clear bit k of `pending`.
    - stay in SHIFT while `pending` still has bits set; otherwise go to SPAWN.
    - Top-down ordering keeps the indices of the lower pending rows valid.
  - HALT: terminal; only `reset` leaves it.
- `land` outside MOVE is ignored. It is not queued.
- `row_full` outside CAPT is ignored.
- `shift_row` is all-zero in every state except SHIFT.

## Timing
- Reset values:
  - FSM enters SPAWN, so `state`=100 in the first cycle after reset releases.
  - `shift_row`=0, `lines`=0, `score`=0, `game_over`=0, `busy`=1.
  - `pending` is cleared.
- Reset asserted mid-sequence (any state, including SHIFT and HALT) aborts the sequence. There is no partial-shift recovery; the row array is reset by the same signal.
- Landing with no full rows:
  - `land` sampled in cycle T.
  - WRITE in T+1, CHECK in T+2, CAPT in T+3, SPAWN in T+4, MOVE in T+5 if `spawn_ok`=1.
- n cleared rows: SHIFT occupies n consecutive cycles starting at T+4, then SPAWN at T+4+n.
- `row_full` must be valid in the CAPT cycle, i.e. the row array's flag registered on the CHECK edge.
- `lines`/`score` update at the edge that leaves CAPT.

## Configuration
- `CLEAR_SCORE_EN`:
  - defined: in CAPT, add to `score` by popcount of `row_full`: 1 row→40, 2→100, 3→300, ≥4→1200. Saturate at 2^SCORE_W-1.
  - undefined: no score register or adder exists; `score` is constant 0.

## Test plan
- Reset with `spawn_ok`=1: `state` sequence 100 then 001 (SPAWN, then MOVE); `lines`=0, `busy` falls in the second cycle.
- `land` pulse, `row_full`=0: `state` sequence 010, 000, 001, 100, 001; `shift_row` stays 0; `lines` unchanged.
- `land`, `row_full` with bit 19 set (ROWS=20): one SHIFT cycle with `shift_row`=20'hFFFFF; `lines`=1; `score`=40 with `CLEAR_SCORE_EN`.
- `land`, `row_full` bits 17 and 19 set:
  - two SHIFT cycles, `shift_row`=20'h3FFFF then 20'hFFFFF.
  - `lines`=2; `score`=100 with `CLEAR_SCORE_EN`.
- `spawn_ok`=0 in SPAWN: HALT with `state`=000 and `game_over`=1; later `land` pulses have no effect; `reset` low returns the FSM to SPAWN.
- `lines` preloaded to 16'hFFFF via repeated clears, then a 3-row clear: `lines` holds at 16'hFFFF; `reset` pulsed mid-SHIFT gives all outputs their reset values on the next cycle.
